// File: rtl/condicionador_disparo_if.sv
// ============================================================================
// Module   : condicionador_disparo_if
// Brief    : Pushbutton-side / trigger-side signal bundle of the conditioner.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface condicionador_disparo_if;
  logic       Botao;
  logic       Disparo;
  logic       Pressionado;
  logic [7:0] Rejeicoes;

  // master: board/button side; slave: the conditioner itself
  modport master (output Botao, input Disparo, input Pressionado, input Rejeicoes);
  modport slave  (input Botao, output Disparo, output Pressionado, output Rejeicoes);
endinterface

`default_nettype wire

// File: rtl/condicionador_disparo.sv
// ============================================================================
// Module   : condicionador_disparo
// Brief    : Synchronises and debounces a raw pushbutton and emits a one-cycle
//            Disparo pulse per press. Optional macro AUTO_REPEAT_EN adds
//            periodic re-triggering while the button stays held.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module condicionador_disparo #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  wire logic               Clk,
  input  wire logic               Reset,
  condicionador_disparo_if.slave  bus
);

  typedef enum logic [1:0] {
    SOLTO      = 2'd0,
    CONF_PRESS = 2'd1,
    PRESSO     = 2'd2,
    CONF_SOLTA = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic             c_released = (ACTIVE_LOW != 0);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned      c_rep_w    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);
  localparam logic [c_rep_w-1:0] c_rep_one  = c_rep_w'(1);
  logic [c_rep_w-1:0] r_rcnt;
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pressed;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_disparo;
  logic             r_press;
  logic [7:0]       r_rej;
  logic [7:0]       w_rej_next;

  // Synchroniser resets to the released level so reset release never looks like a press
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= c_released;
      r_sync2 <= c_released;
    end else begin
      r_sync1 <= bus.Botao;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed  = r_sync2 ^ c_released;
  assign w_rej_next = (r_rej == 8'hFF) ? r_rej : r_rej + 8'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= SOLTO;
      r_cnt     <= '0;
      r_disparo <= 1'b0;
      r_press   <= 1'b0;
      r_rej     <= 8'd0;
`ifdef AUTO_REPEAT_EN
      r_rcnt    <= '0;
`endif
    end else begin
      r_disparo <= 1'b0;
      case (r_state)
        SOLTO: begin
`ifdef AUTO_REPEAT_EN
          r_rcnt <= '0;
`endif
          if (w_pressed) begin
            r_state <= CONF_PRESS;
            r_cnt   <= '0;
          end
        end
        CONF_PRESS: begin
          if (!w_pressed) begin
            r_state <= SOLTO;
            r_rej   <= w_rej_next;
          end else if (r_cnt == c_cnt_last) begin
            r_state   <= PRESSO;
            r_disparo <= 1'b1;
            r_press   <= 1'b1;
`ifdef AUTO_REPEAT_EN
            r_rcnt    <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        PRESSO: begin
          if (!w_pressed) begin
            r_state <= CONF_SOLTA;
            r_cnt   <= '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (r_rcnt == c_rep_last) begin
            r_disparo <= 1'b1;
            r_rcnt    <= '0;
          end else begin
            r_rcnt <= r_rcnt + c_rep_one;
          end
`endif
        end
        CONF_SOLTA: begin
          // A bounce back to pressed resumes the held state without a new trigger
          if (w_pressed) begin
            r_state <= PRESSO;
            r_rej   <= w_rej_next;
          end else if (r_cnt == c_cnt_last) begin
            r_state <= SOLTO;
            r_press <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: r_state <= SOLTO;
      endcase
    end
  end

  assign bus.Disparo     = r_disparo;
  assign bus.Pressionado = r_press;
  assign bus.Rejeicoes   = r_rej;

endmodule

`default_nettype wire

// File: tb/tb_condicionador_disparo.sv
// ============================================================================
// Module   : tb_condicionador_disparo
// Brief    : Directed vector bench for condicionador_disparo (DEBOUNCE=4, REPEAT=10).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_condicionador_disparo;

  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned REP = 10;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  condicionador_disparo_if bus();

  condicionador_disparo #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CW),
    .ACTIVE_LOW      (1),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic       b;
    logic       d;
    logic       p;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic d, input logic p, input logic [7:0] r);
    chk({tag, ".disparo"}, {7'd0, bus.Disparo}, {7'd0, d});
    chk({tag, ".press"},   {7'd0, bus.Pressionado}, {7'd0, p});
    chk({tag, ".rej"},     bus.Rejeicoes, r);
  endtask

  task automatic step(input logic b);
    bus.Botao = b;
    @(posedge Clk);
    #1;
  endtask

  function automatic void add(input logic b, input logic d, input logic p, input logic [7:0] r);
    vec_t v;
    v.b = b; v.d = d; v.p = p; v.r = r;
    vecs.push_back(v);
  endfunction

  function automatic logic rep_pulse(input int row);
`ifdef AUTO_REPEAT_EN
    return (row >= 6) && ((row - 6) % 10 == 0);
`else
    return (row == 6);
`endif
  endfunction

  initial begin
    int pulses;
    logic [7:0] exp_rej;

    // Row index = edge number - 1 after the first edge that samples the new level.
    for (int i = 0; i < 20; i++) add(1'b0, rep_pulse(i), i >= 6, 8'd0);     // press out of reset
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, i < 6, 8'd0);              // release
    for (int i = 0; i < 15; i++) add((i == 2), (i == 9), i >= 9, (i >= 4) ? 8'd1 : 8'd0); // bounce
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, i < 6, 8'd1);              // release

    // Reset with the button held: everything cleared while reset is high
    bus.Botao = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 8'd0);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].b);
      chk_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].r);
    end

    // Reset asserted with the debounce counter at 2
    for (int k = 1; k <= 5; k++) begin
      step(1'b0);
      chk_all($sformatf("pre_rst%0d", k), 1'b0, 1'b0, 8'd1);
    end
    Reset = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 8'd0);
    step(1'b0);
    step(1'b0);
    chk_all("rst_hold", 1'b0, 1'b0, 8'd0);
    Reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0);
      chk_all($sformatf("post_rst%0d", k), (k == 7), (k >= 7), 8'd0);
    end

    // 300 aborted presses: each 0,1,1,1 pattern yields exactly one rejection
    bus.Botao = 1'b1;
    Reset = 1'b1;
    step(1'b1);
    step(1'b1);
    Reset = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 300; n++) begin
      step(1'b0); pulses += int'(bus.Disparo);
      step(1'b1); pulses += int'(bus.Disparo);
      step(1'b1); pulses += int'(bus.Disparo);
      step(1'b1); pulses += int'(bus.Disparo);
      exp_rej = (n > 255) ? 8'hFF : 8'(n);
      chk($sformatf("sat%0d", n), bus.Rejeicoes, exp_rej);
    end
    chk("sat_no_disparo", 8'(pulses), 8'd0);
    chk("sat_no_press", {7'd0, bus.Pressionado}, 8'd0);

    // Long hold: one trigger, or one every REPEAT_CYCLES with auto-repeat
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      pulses += int'(bus.Disparo);
      chk($sformatf("hold%0d", i), {7'd0, bus.Disparo}, {7'd0, rep_pulse(i)});
    end
`ifdef AUTO_REPEAT_EN
    chk("hold_count", 8'(pulses), 8'd4);
`else
    chk("hold_count", 8'(pulses), 8'd1);
`endif
    chk("hold_rej", bus.Rejeicoes, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
